// File: rtl/cell_in_loader.sv
// cell_in_loader: input buffer of the LSTM cell.
// Captures M elements written by the array output stage (any order, rewrites allowed),
// then streams them to the cell in ascending address order over valid/ready.
//
// Ports:
//   sys_clk          system clock, rising edge
//   reset            asynchronous active-high reset
//   start_load_cell  arms the buffer for a new load (restarts an ongoing fill)
//   data_in          element from the output stage
//   address_write    target address of data_in
//   we               write strobe
//   buffer_full      high while draining (all M elements captured)
//   cell_data        element presented to the cell
//   cell_valid       cell_data valid
//   cell_ready       cell accepts cell_data
//   cell_last        high with cell_valid on element M-1
//   done             one-cycle pulse after the final handshake
//   wr_err           sticky write-error flag, cleared by start_load_cell
module cell_in_loader #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned ELEMENT_BITS = 8,
  parameter int unsigned M            = 9
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start_load_cell,
  input  logic [ELEMENT_BITS-1:0] data_in,
  input  logic [FEATURE_BITS-1:0] address_write,
  input  logic                    we,
  output logic                    buffer_full,
  output logic [ELEMENT_BITS-1:0] cell_data,
  output logic                    cell_valid,
  input  logic                    cell_ready,
  output logic                    cell_last,
  output logic                    done,
  output logic                    wr_err
);

  localparam logic [FEATURE_BITS-1:0] LpM    = FEATURE_BITS'(M);
  localparam logic [FEATURE_BITS-1:0] LpLast = FEATURE_BITS'(M - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e                  r_state;
  logic [ELEMENT_BITS-1:0] r_array [M];
  logic [M-1:0]            r_written;
  logic [FEATURE_BITS-1:0] r_fill_cnt;
  logic [FEATURE_BITS-1:0] r_rd_ptr;
  logic                    r_done;
  logic                    r_wr_err;

  logic w_addr_ok;
  logic w_new_addr;

  assign w_addr_ok  = (address_write < LpM);
  // Only meaningful when w_addr_ok; the AND keeps an out-of-range index harmless.
  assign w_new_addr = w_addr_ok && !r_written[address_write];

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_written  <= '0;
      r_fill_cnt <= '0;
      r_rd_ptr   <= '0;
      r_done     <= 1'b0;
      r_wr_err   <= 1'b0;
      for (int i = 0; i < int'(M); i++) begin
        r_array[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_load_cell) begin
            r_state    <= StFill;
            r_written  <= '0;
            r_fill_cnt <= '0;
            r_wr_err   <= 1'b0;
          end
        end
        StFill: begin
          // A restart wins over a coincident write.
          if (start_load_cell) begin
            r_written  <= '0;
            r_fill_cnt <= '0;
            r_wr_err   <= 1'b0;
          end else if (we) begin
            if (w_addr_ok) begin
              r_array[address_write] <= data_in;
              if (w_new_addr) begin
                r_written[address_write] <= 1'b1;
                r_fill_cnt               <= r_fill_cnt + 1'b1;
                // This write supplies the last missing address.
                if (r_fill_cnt == LpLast) begin
                  r_state <= StDrain;
                end
              end
            end else begin
              r_wr_err <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (we) begin
            r_wr_err <= 1'b1;
          end
          if (cell_ready) begin
            if (r_rd_ptr == LpLast) begin
              r_state  <= StIdle;
              r_rd_ptr <= '0;
              r_done   <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cell_valid  = (r_state == StDrain);
  assign buffer_full = cell_valid;
  assign cell_data   = cell_valid ? r_array[r_rd_ptr] : '0;
  assign cell_last   = cell_valid && (r_rd_ptr == LpLast);
  assign done        = r_done;
  assign wr_err      = r_wr_err;

endmodule

// File: tb/tb_cell_in_loader.sv
module tb_cell_in_loader;
  localparam int FB = 4;
  localparam int EB = 8;
  localparam int M  = 9;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic          start_load_cell;
  logic [EB-1:0] data_in;
  logic [FB-1:0] address_write;
  logic          we;
  logic          buffer_full;
  logic [EB-1:0] cell_data;
  logic          cell_valid;
  logic          cell_ready;
  logic          cell_last;
  logic          done;
  logic          wr_err;

  cell_in_loader #(.FEATURE_BITS(FB), .ELEMENT_BITS(EB), .M(M)) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .start_load_cell (start_load_cell),
    .data_in         (data_in),
    .address_write   (address_write),
    .we              (we),
    .buffer_full     (buffer_full),
    .cell_data       (cell_data),
    .cell_valid      (cell_valid),
    .cell_ready      (cell_ready),
    .cell_last       (cell_last),
    .done            (done),
    .wr_err          (wr_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model of one load: contents, which addresses are present, and the phase.
  logic [EB-1:0] mdl_mem [M];
  bit            mdl_wr  [M];
  int            mdl_cnt;
  bit            mdl_err;
  int            mdl_phase;  // 0 idle, 1 fill, 2 drain

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < M; i++) begin
      mdl_mem[i] = '0;
      mdl_wr[i]  = 1'b0;
    end
    mdl_cnt   = 0;
    mdl_err   = 1'b0;
    mdl_phase = 0;
  endtask

  task automatic do_start(input bit with_write);
    start_load_cell = 1'b1;
    cell_ready      = 1'b0;
    if (with_write) begin
      we            = 1'b1;
      address_write = 4'd0;
      data_in       = 8'h55;
    end
    tick();
    start_load_cell = 1'b0;
    we              = 1'b0;
    if (mdl_phase != 2) begin
      mdl_phase = 1;
      mdl_cnt   = 0;
      mdl_err   = 1'b0;
      for (int i = 0; i < M; i++) mdl_wr[i] = 1'b0;
    end
    n_vec++;
    if (wr_err !== mdl_err || cell_valid !== (mdl_phase == 2)) begin
      n_miss++;
      $display("FAIL start: wr_err=%0b valid=%0b expected wr_err=%0b valid=%0b",
               wr_err, cell_valid, mdl_err, mdl_phase == 2);
    end
  endtask

  task automatic do_write(input logic [FB-1:0] a, input logic [EB-1:0] d);
    we            = 1'b1;
    address_write = a;
    data_in       = d;
    cell_ready    = 1'b0;
    tick();
    we = 1'b0;
    if (mdl_phase == 1) begin
      if (int'(a) < M) begin
        mdl_mem[a] = d;
        if (!mdl_wr[a]) begin
          mdl_wr[a] = 1'b1;
          mdl_cnt++;
          if (mdl_cnt == M) mdl_phase = 2;
        end
      end else begin
        mdl_err = 1'b1;
      end
    end else if (mdl_phase == 2) begin
      mdl_err = 1'b1;
    end
    n_vec++;
    if (wr_err !== mdl_err) begin
      n_miss++;
      $display("FAIL write_err: addr=%0d got %0b expected %0b", a, wr_err, mdl_err);
    end
    n_vec++;
    if (cell_valid !== (mdl_phase == 2) || buffer_full !== (mdl_phase == 2)) begin
      n_miss++;
      $display("FAIL write_valid: addr=%0d valid=%0b full=%0b expected %0b",
               a, cell_valid, buffer_full, mdl_phase == 2);
    end
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0, 2: random ready.
  task automatic drain(input int mode, input int stop_at);
    int k   = 0;
    int cyc = 0;
    while (k < stop_at && cyc < 20 * M) begin
      if (mode == 0)      cell_ready = 1'b1;
      else if (mode == 1) cell_ready = (cyc % 3 == 0);
      else                cell_ready = 1'($urandom_range(0, 1));
      n_vec++;
      if (cell_valid !== 1'b1 || buffer_full !== 1'b1 || cell_data !== mdl_mem[k] ||
          cell_last !== (k == M - 1) || done !== 1'b0) begin
        n_miss++;
        $display("FAIL drain[%0d]: valid=%0b full=%0b data=%02h last=%0b done=%0b expected data=%02h last=%0b",
                 k, cell_valid, buffer_full, cell_data, cell_last, done, mdl_mem[k], k == M - 1);
      end
      tick();
      if (cell_ready) k++;
      cyc++;
    end
    cell_ready = 1'b0;
    if (k < stop_at) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d handshakes expected %0d", k, stop_at);
    end
    if (stop_at == M) begin
      mdl_phase = 0;
      n_vec++;
      if (done !== 1'b1 || cell_valid !== 1'b0 || buffer_full !== 1'b0) begin
        n_miss++;
        $display("FAIL done_pulse: done=%0b valid=%0b full=%0b expected 1 0 0",
                 done, cell_valid, buffer_full);
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin
        n_miss++;
        $display("FAIL done_width: got %0b expected 0", done);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (cell_valid !== 1'b0 || buffer_full !== 1'b0 || cell_data !== '0 ||
        cell_last !== 1'b0 || done !== 1'b0 || wr_err !== 1'b0) begin
      n_miss++;
      $display("FAIL %s: valid=%0b full=%0b data=%02h last=%0b done=%0b err=%0b expected all 0",
               tag, cell_valid, buffer_full, cell_data, cell_last, done, wr_err);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < M; i++) do_write(FB'(i), EB'($urandom));
  endtask

  task automatic test_reset();
    #3;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("after_release");
    do_write(4'd2, 8'h99);  // ignored while idle
  endtask

  task automatic test_in_order();
    do_start(1'b0);
    for (int i = 0; i < M; i++) do_write(FB'(i), EB'(8'h10 + i));
    drain(0, M);
    do_write(4'd0, 8'hFF);  // back in idle: ignored
  endtask

  task automatic test_out_of_order();
    int order [M] = '{8, 0, 7, 1, 6, 2, 5, 3, 4};
    do_start(1'b0);
    for (int i = 0; i < M; i++) do_write(FB'(order[i]), EB'($urandom));
    drain(0, M);
  endtask

  task automatic test_duplicate();
    do_start(1'b0);
    do_write(4'd3, 8'hAA);
    do_write(4'd3, 8'hBB);
    for (int i = 0; i < M; i++) if (i != 3) do_write(FB'(i), EB'($urandom));
    drain(0, M);
  endtask

  task automatic test_backpressure();
    do_start(1'b0);
    fill_random();
    drain(1, M);
  endtask

  task automatic test_errors();
    do_start(1'b0);
    for (int i = 0; i < 5; i++) do_write(FB'(i), EB'($urandom));
    do_write(4'd9, 8'h77);
    do_write(4'd15, 8'h78);
    for (int i = 5; i < M; i++) do_write(FB'(i), EB'($urandom));
    do_write(4'd2, 8'hEE);  // during drain: dropped
    drain(2, M);
    do_start(1'b0);         // clears the sticky flag
    fill_random();
    drain(0, M);
  endtask

  task automatic test_restart();
    do_start(1'b0);
    for (int i = 0; i < 4; i++) do_write(FB'(i), EB'($urandom));
    do_start(1'b1);         // restart with a coincident, dropped write
    for (int i = M - 1; i >= 0; i--) do_write(FB'(i), EB'($urandom));
    drain(2, M);
  endtask

  task automatic test_reset_mid_drain();
    do_start(1'b0);
    fill_random();
    drain(0, 4);
    #2;
    reset = 1'b1;
    #1;
    mdl_reset();
    check_all_zero("reset_mid_drain");
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("after_mid_reset");
    do_start(1'b0);
    fill_random();
    drain(0, M);
  endtask

  task automatic test_random();
    int order [M];
    for (int load = 0; load < 6; load++) begin
      for (int i = 0; i < M; i++) order[i] = i;
      for (int i = M - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int t = order[i];
        order[i] = order[j];
        order[j] = t;
      end
      do_start(1'b0);
      for (int i = 0; i < M; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) do_write(FB'(order[i-1]), EB'($urandom));
        if ($urandom_range(0, 7) == 0) do_write(FB'($urandom_range(M, 15)), EB'($urandom));
        do_write(FB'(order[i]), EB'($urandom));
      end
      drain(2, M);
    end
  endtask

  initial begin
    reset           = 1'b1;
    start_load_cell = 1'b0;
    we              = 1'b0;
    cell_ready      = 1'b0;
    data_in         = '0;
    address_write   = '0;
    mdl_reset();
    test_reset();
    test_in_order();
    test_out_of_order();
    test_duplicate();
    test_backpressure();
    test_errors();
    test_restart();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
